// File: rtl/collision_scanner.sv
// Pairwise bounding-box collision scanner over a small car table.
// A start snapshots the live table, then one pair is tested per cycle in fixed order.
module collision_scanner #(
  parameter int unsigned NUM_CARS = 12,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned CAR_LEN  = 60,
  parameter int unsigned CAR_WID  = 30,
  parameter int unsigned CNT_W    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [1:0]         wr_orient,
  input  logic               wr_active,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               collision,
  output logic [IDX_W-1:0]   hit_a,
  output logic [IDX_W-1:0]   hit_b,
  output logic [CNT_W-1:0]   hit_count
);

  localparam int unsigned SumW = COORD_W + 1;
  localparam logic [SumW-1:0] LenS = SumW'(CAR_LEN);
  localparam logic [SumW-1:0] WidS = SumW'(CAR_WID);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] stateQ;

  logic [COORD_W-1:0] liveX [NUM_CARS];
  logic [COORD_W-1:0] liveY [NUM_CARS];
  logic [1:0]         liveOrient [NUM_CARS];
  logic               liveActive [NUM_CARS];

  logic [COORD_W-1:0] liveXD [NUM_CARS];
  logic [COORD_W-1:0] liveYD [NUM_CARS];
  logic [1:0]         liveOrientD [NUM_CARS];
  logic               liveActiveD [NUM_CARS];

  logic [COORD_W-1:0] snapX [NUM_CARS];
  logic [COORD_W-1:0] snapY [NUM_CARS];
  logic [1:0]         snapOrient [NUM_CARS];
  logic               snapActive [NUM_CARS];

  logic [IDX_W-1:0] iQ, jQ, firstAQ, firstBQ;
  logic             foundQ;
  logic [CNT_W-1:0] cntQ;

  // Next live table; also feeds the snapshot so a same-cycle write is captured.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CARS; k++) begin
      liveXD[k]      = liveX[k];
      liveYD[k]      = liveY[k];
      liveOrientD[k] = liveOrient[k];
      liveActiveD[k] = liveActive[k];
    end
    if (wr_en && (32'(wr_idx) < NUM_CARS)) begin
      liveXD[wr_idx]      = wr_x;
      liveYD[wr_idx]      = wr_y;
      liveOrientD[wr_idx] = wr_orient;
      liveActiveD[wr_idx] = wr_active;
    end
  end

  logic [SumW-1:0] xa, ya, xb, yb, wa, ha, wb, hb;
  logic            pairHit, lastPair, foundN;
  logic [IDX_W-1:0] aN, bN;
  logic [CNT_W-1:0] cntN;

  // Extents are widened by one bit so boxes near the far edge never wrap.
  always_comb begin
    xa = {1'b0, snapX[iQ]};
    ya = {1'b0, snapY[iQ]};
    xb = {1'b0, snapX[jQ]};
    yb = {1'b0, snapY[jQ]};
    wa = snapOrient[iQ][0] ? WidS : LenS;
    ha = snapOrient[iQ][0] ? LenS : WidS;
    wb = snapOrient[jQ][0] ? WidS : LenS;
    hb = snapOrient[jQ][0] ? LenS : WidS;
    pairHit = snapActive[iQ] && snapActive[jQ] &&
              (xa < xb + wb) && (xb < xa + wa) &&
              (ya < yb + hb) && (yb < ya + ha);
    lastPair = (iQ == IDX_W'(NUM_CARS - 2)) && (jQ == IDX_W'(NUM_CARS - 1));
    foundN   = foundQ | pairHit;
    aN       = (pairHit && !foundQ) ? iQ : firstAQ;
    bN       = (pairHit && !foundQ) ? jQ : firstBQ;
    cntN     = (pairHit && (cntQ != '1)) ? cntQ + CNT_W'(1) : cntQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= IDLE;
      iQ        <= '0;
      jQ        <= '0;
      firstAQ   <= '0;
      firstBQ   <= '0;
      foundQ    <= 1'b0;
      cntQ      <= '0;
      collision <= 1'b0;
      hit_a     <= '0;
      hit_b     <= '0;
      hit_count <= '0;
      for (int unsigned k = 0; k < NUM_CARS; k++) begin
        liveX[k]      <= '0;
        liveY[k]      <= '0;
        liveOrient[k] <= '0;
        liveActive[k] <= 1'b0;
        snapX[k]      <= '0;
        snapY[k]      <= '0;
        snapOrient[k] <= '0;
        snapActive[k] <= 1'b0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CARS; k++) begin
        liveX[k]      <= liveXD[k];
        liveY[k]      <= liveYD[k];
        liveOrient[k] <= liveOrientD[k];
        liveActive[k] <= liveActiveD[k];
      end
      case (stateQ)
        IDLE: begin
          if (start) begin
            for (int unsigned k = 0; k < NUM_CARS; k++) begin
              snapX[k]      <= liveXD[k];
              snapY[k]      <= liveYD[k];
              snapOrient[k] <= liveOrientD[k];
              snapActive[k] <= liveActiveD[k];
            end
            iQ      <= '0;
            jQ      <= IDX_W'(1);
            foundQ  <= 1'b0;
            firstAQ <= '0;
            firstBQ <= '0;
            cntQ    <= '0;
            stateQ  <= SCAN;
          end
        end
        SCAN: begin
          foundQ  <= foundN;
          firstAQ <= aN;
          firstBQ <= bN;
          cntQ    <= cntN;
          if (lastPair) begin
            collision <= foundN;
            hit_a     <= aN;
            hit_b     <= bN;
            hit_count <= cntN;
            stateQ    <= DONE;
          end else if (jQ == IDX_W'(NUM_CARS - 1)) begin
            iQ <= iQ + IDX_W'(1);
            jQ <= iQ + IDX_W'(2);
          end else begin
            jQ <= jQ + IDX_W'(1);
          end
        end
        DONE:    stateQ <= IDLE;
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign busy = (stateQ == SCAN);
  assign done = (stateQ == DONE);

endmodule

// File: tb/tb_collision_scanner.sv
// Directed self-checking bench for collision_scanner at default parameters.
module tb_collision_scanner;

  localparam int NumCars = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_idx = '0;
  logic [9:0] wr_x = '0;
  logic [9:0] wr_y = '0;
  logic [1:0] wr_orient = '0;
  logic       wr_active = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, collision;
  logic [3:0] hit_a, hit_b;
  logic [6:0] hit_count;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  collision_scanner dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_orient (wr_orient),
    .wr_active (wr_active),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .collision (collision),
    .hit_a     (hit_a),
    .hit_b     (hit_b),
    .hit_count (hit_count)
  );

  task automatic writeCar(input int idx, input int x, input int y, input int orient,
                          input bit act);
    wr_en = 1'b1; wr_idx = 4'(idx); wr_x = 10'(x); wr_y = 10'(y);
    wr_orient = 2'(orient); wr_active = act;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic clearCars;
    for (int k = 0; k < NumCars; k++) writeCar(k, 0, 0, 0, 1'b0);
  endtask

  // Pulses start; reports edges from the sampling edge to done (-1 on timeout).
  task automatic runScan(output int doneAt, output int busyCnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    doneAt = -1;
    busyCnt = 0;
    for (int c = 1; c <= 200; c++) begin
      if (busy) busyCnt++;
      @(posedge clk); #1;
      if (done) begin doneAt = c; break; end
    end
  endtask

  task automatic test_reset;
    #1;
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("FAIL reset_done: got %b want 0", done); end
    nCompared++; if ({collision, hit_a, hit_b, hit_count} !== 16'd0) begin nMismatched++;
      $display("FAIL reset_results: got %b/%0d/%0d/%0d want all 0", collision, hit_a, hit_b, hit_count); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic_hit;
    int d, b;
    clearCars();
    writeCar(0, 100, 100, 0, 1'b1);
    writeCar(1, 130, 110, 1, 1'b1);
    runScan(d, b);
    nCompared++; if (d !== 66) begin nMismatched++; $display("FAIL basic_latency: got %0d want 66", d); end
    nCompared++; if (b !== 66) begin nMismatched++; $display("FAIL basic_busy_cycles: got %0d want 66", b); end
    nCompared++; if (collision !== 1'b1) begin nMismatched++; $display("FAIL basic_collision: got %b want 1", collision); end
    nCompared++; if (hit_a !== 4'd0 || hit_b !== 4'd1) begin nMismatched++;
      $display("FAIL basic_pair: got %0d,%0d want 0,1", hit_a, hit_b); end
    nCompared++; if (hit_count !== 7'd1) begin nMismatched++; $display("FAIL basic_count: got %0d want 1", hit_count); end
    @(posedge clk); #1;
    nCompared++; if (done !== 1'b0 || busy !== 1'b0) begin nMismatched++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b want 0,0", done, busy); end
    nCompared++; if (collision !== 1'b1) begin nMismatched++; $display("FAIL basic_hold: got %b want 1", collision); end
  endtask

  task automatic test_touch;
    int d, b;
    clearCars();
    writeCar(0, 100, 100, 0, 1'b1);
    writeCar(1, 160, 100, 0, 1'b1);
    runScan(d, b);
    nCompared++; if (d !== 66) begin nMismatched++; $display("FAIL touch_latency: got %0d want 66", d); end
    nCompared++; if (collision !== 1'b0 || hit_count !== 7'd0) begin nMismatched++;
      $display("FAIL touch_result: got %b/%0d want 0/0", collision, hit_count); end
    nCompared++; if (hit_a !== 4'd0 || hit_b !== 4'd0) begin nMismatched++;
      $display("FAIL touch_pair: got %0d,%0d want 0,0", hit_a, hit_b); end
  endtask

  task automatic test_triple;
    int d, b;
    clearCars();
    writeCar(2, 200, 200, 1, 1'b1);
    writeCar(5, 200, 200, 1, 1'b1);
    writeCar(9, 200, 200, 1, 1'b1);
    runScan(d, b);
    nCompared++; if (collision !== 1'b1) begin nMismatched++; $display("FAIL triple_collision: got %b want 1", collision); end
    nCompared++; if (hit_a !== 4'd2 || hit_b !== 4'd5) begin nMismatched++;
      $display("FAIL triple_pair: got %0d,%0d want 2,5", hit_a, hit_b); end
    nCompared++; if (hit_count !== 7'd3) begin nMismatched++; $display("FAIL triple_count: got %0d want 3", hit_count); end
  endtask

  task automatic test_edge_coords;
    int d, b;
    clearCars();
    writeCar(10, 990, 990, 1, 1'b1);
    writeCar(11, 1000, 1000, 0, 1'b1);
    runScan(d, b);
    nCompared++; if (collision !== 1'b1) begin nMismatched++; $display("FAIL edge_collision: got %b want 1", collision); end
    nCompared++; if (hit_a !== 4'd10 || hit_b !== 4'd11 || hit_count !== 7'd1) begin nMismatched++;
      $display("FAIL edge_pair: got %0d,%0d,%0d want 10,11,1", hit_a, hit_b, hit_count); end
  endtask

  task automatic test_write_through;
    int d;
    clearCars();
    writeCar(0, 100, 100, 0, 1'b1);
    wr_en = 1'b1; wr_idx = 4'd1; wr_x = 10'd130; wr_y = 10'd110; wr_orient = 2'd1; wr_active = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    d = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (done) begin d = c; break; end
    end
    nCompared++; if (d !== 66) begin nMismatched++; $display("FAIL wthru_latency: got %0d want 66", d); end
    nCompared++; if (collision !== 1'b1 || hit_b !== 4'd1) begin nMismatched++;
      $display("FAIL wthru_result: got %b,%0d want 1,1", collision, hit_b); end
  endtask

  task automatic test_write_during_scan;
    int d, b;
    clearCars();
    writeCar(0, 100, 100, 0, 1'b1);
    writeCar(1, 130, 110, 1, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    writeCar(1, 500, 500, 0, 1'b1);
    d = -1;
    for (int c = 1; c <= 200; c++) begin
      if (done) begin d = c; break; end
      @(posedge clk); #1;
    end
    nCompared++; if (d < 0) begin nMismatched++; $display("FAIL wscan_timeout: got no done want done"); end
    nCompared++; if (collision !== 1'b1 || hit_count !== 7'd1) begin nMismatched++;
      $display("FAIL wscan_current: got %b/%0d want 1/1", collision, hit_count); end
    @(posedge clk); #1;
    runScan(d, b);
    nCompared++; if (collision !== 1'b0 || hit_count !== 7'd0) begin nMismatched++;
      $display("FAIL wscan_next: got %b/%0d want 0/0", collision, hit_count); end
  endtask

  task automatic test_reset_mid_scan;
    int d, b, nDone;
    clearCars();
    writeCar(0, 100, 100, 0, 1'b1);
    writeCar(1, 130, 110, 1, 1'b1);
    runScan(d, b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    nCompared++; if (busy !== 1'b0 || done !== 1'b0) begin nMismatched++;
      $display("FAIL abort_busy: got busy=%b done=%b want 0,0", busy, done); end
    nCompared++; if ({collision, hit_a, hit_b, hit_count} !== 16'd0) begin nMismatched++;
      $display("FAIL abort_results: got %b/%0d/%0d/%0d want all 0", collision, hit_a, hit_b, hit_count); end
    @(posedge clk); #1 rst = 1'b0;
    nDone = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (done) nDone++;
    end
    nCompared++; if (nDone !== 0) begin nMismatched++; $display("FAIL abort_no_done: got %0d want 0", nDone); end
    runScan(d, b);
    nCompared++; if (collision !== 1'b0) begin nMismatched++;
      $display("FAIL abort_table_cleared: got %b want 0", collision); end
  endtask

  task automatic test_double_start;
    int nDone;
    clearCars();
    writeCar(2, 200, 200, 1, 1'b1);
    writeCar(5, 200, 200, 1, 1'b1);
    writeCar(9, 200, 200, 1, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nDone = 0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 10 || c == 20) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) nDone++;
    end
    nCompared++; if (nDone !== 1) begin nMismatched++; $display("FAIL dstart_done_count: got %0d want 1", nDone); end
    nCompared++; if (hit_a !== 4'd2 || hit_b !== 4'd5 || hit_count !== 7'd3) begin nMismatched++;
      $display("FAIL dstart_result: got %0d,%0d,%0d want 2,5,3", hit_a, hit_b, hit_count); end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_touch();
    test_triple();
    test_edge_coords();
    test_write_through();
    test_write_during_scan();
    test_reset_mid_scan();
    test_double_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
